// File: rtl/npu_axi_pkg.sv
// Shared AXI4 types for the EdgeNPU memory slave and DMA engine.
// Burst/response encodings follow the AXI4 wire values.
package npu_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic axi_resp_e resp_merge(input axi_resp_e a, input axi_resp_e b);
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/npu_axi_lfsr.sv
// 16-bit Galois LFSR used to generate pseudo-random handshake stalls.
module npu_axi_lfsr
  import npu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/npu_axi_mem_slave.sv
// AXI4 word-addressed RAM slave: INCR/FIXED bursts, byte strobes, programmable read latency.
// Define AXI_SLV_STALL_EN to insert LFSR-driven ready/valid stalls.
module npu_axi_mem_slave
  import npu_axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 40,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           MEM_DEPTH  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           READ_LAT   = 2,
  parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned MAW    = $clog2(MEM_DEPTH);
  localparam int unsigned IDXW   = ADDR_WIDTH + 2;
  localparam logic [3:0]  LAT_LAST = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

  // Signed word index so addresses below BASE_ADDR show up as negative
  typedef logic signed [IDXW-1:0] idx_t;
  localparam idx_t DEPTH_I = idx_t'(MEM_DEPTH);

  function automatic idx_t to_idx(input logic [ADDR_WIDTH-1:0] a);
    idx_t d;
    d = $signed({2'b00, a}) - $signed({2'b00, BASE_ADDR});
    return d >>> OFFS;
  endfunction

  function automatic logic in_range(input idx_t i);
    return (i >= idx_t'(0)) && (i < DEPTH_I);
  endfunction

  // Bursts are contiguous, so checking the end points decides the whole burst
  function automatic axi_resp_e range_resp(input idx_t first, input logic [7:0] len,
                                           input logic [1:0] burst);
    idx_t last;
    if (burst != BURST_FIXED && burst != BURST_INCR) return RESP_SLVERR;
    last = (burst == BURST_INCR) ? first + idx_t'(len) : first;
    if (!in_range(first) || !in_range(last)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic stall_a, stall_r;

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr;
  logic [13:0] unused_lfsr;
  npu_axi_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr)
  );
  assign stall_a     = ~lfsr[0];
  assign stall_r     = ~lfsr[1];
  assign unused_lfsr = lfsr[15:2];
`else
  localparam logic [15:0] unused_seed = LFSR_SEED;
  assign stall_a = 1'b0;
  assign stall_r = 1'b0;
`endif

  logic unused_size;
  assign unused_size = ^{awsize, arsize};

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write channel
  wr_state_e w_state_q, w_state_d;
  idx_t      w_idx_q, w_idx_d;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic      w_fixed_q, w_fixed_d, w_bad_q, w_bad_d;
  axi_resp_e w_resp_q, w_resp_d;
  logic      mem_we;

  assign awready = (w_state_q == W_IDLE) && !stall_a;
  assign wready  = (w_state_q == W_DATA) && !stall_a;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = w_resp_q;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_bad_d   = w_bad_q;
    w_resp_d  = w_resp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_idx_d   = to_idx(awaddr);
          w_len_d   = awlen;
          w_cnt_d   = '0;
          w_fixed_d = (awburst == BURST_FIXED);
          w_bad_d   = (awburst != BURST_FIXED) && (awburst != BURST_INCR);
          w_resp_d  = range_resp(to_idx(awaddr), awlen, awburst);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          mem_we = !w_bad_q && in_range(w_idx_q);
          if (wlast != (w_cnt_q == w_len_q)) w_resp_d = resp_merge(w_resp_q, RESP_SLVERR);
          if (!w_fixed_q) w_idx_d = w_idx_q + idx_t'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_bad_q   <= 1'b0;
      w_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_bad_q   <= w_bad_d;
      w_resp_q  <= w_resp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx_q[MAW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read channel
  rd_state_e r_state_q, r_state_d;
  idx_t      r_idx_q, r_idx_d;
  logic [7:0] r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [3:0] r_lat_q, r_lat_d;
  logic      r_fixed_q, r_fixed_d, r_bad_q, r_bad_d;
  axi_resp_e r_resp_q, r_resp_d;
  logic      rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic      rhs, r_load, r_hit;

  assign arready = (r_state_q == R_IDLE) && !stall_a;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  // A new beat is fetched when the output slot is empty or being drained by a
  // non-final handshake, giving back-to-back beats without a bubble.
  assign rhs    = rvalid_q && rready;
  assign r_load = (r_state_q == R_DATA) && (!rvalid_q || (rhs && !rlast_q)) && !stall_r;
  assign r_hit  = !r_bad_q && in_range(r_idx_q);

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_lat_d   = r_lat_q;
    r_fixed_d = r_fixed_q;
    r_bad_d   = r_bad_q;
    r_resp_d  = r_resp_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_idx_d   = to_idx(araddr);
          r_len_d   = arlen;
          r_beat_d  = '0;
          r_lat_d   = '0;
          r_fixed_d = (arburst == BURST_FIXED);
          r_bad_d   = (arburst != BURST_FIXED) && (arburst != BURST_INCR);
          r_resp_d  = range_resp(to_idx(araddr), arlen, arburst);
          r_state_d = (READ_LAT > 0) ? R_WAIT : R_DATA;
        end
      end
      R_WAIT: begin
        if (r_lat_q == LAT_LAST) r_state_d = R_DATA;
        else                     r_lat_d   = r_lat_q + 4'd1;
      end
      R_DATA: begin
        if (rhs && rlast_q) r_state_d = R_IDLE;
        if (r_load) begin
          r_beat_d = r_beat_q + 8'd1;
          if (!r_fixed_q) r_idx_d = r_idx_q + idx_t'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rhs) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
    if (r_load) begin
      rvalid_d = 1'b1;
      rlast_d  = (r_beat_q == r_len_q);
      rresp_d  = r_resp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_lat_q   <= '0;
      r_fixed_q <= 1'b0;
      r_bad_q   <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_lat_q   <= r_lat_d;
      r_fixed_q <= r_fixed_d;
      r_bad_q   <= r_bad_d;
      r_resp_q  <= r_resp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      if (r_load) rdata_q <= r_hit ? mem[r_idx_q[MAW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_npu_axi_mem_slave.sv
// Self-checking bench for npu_axi_mem_slave against an array-based memory model.
module tb_npu_axi_mem_slave;

  localparam int          AW    = 40;
  localparam int          DW    = 128;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 5;
  localparam logic [39:0] BASE  = 40'h0;

  logic          clk, rst;
  logic [39:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [15:0]   wstrb;
  logic [1:0]    bresp, rresp;

  npu_axi_mem_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (BASE),
    .READ_LAT   (LAT),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk (clk), .rst (rst),
    .awaddr (awaddr), .awlen (awlen), .awsize (awsize), .awburst (awburst),
    .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .araddr (araddr), .arlen (arlen), .arsize (arsize), .arburst (arburst),
    .arvalid (arvalid), .arready (arready),
    .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [DW-1:0] wd_a [256];
  logic [15:0]   ws_a [256];
  logic [DW-1:0] rd_d [256];
  logic [1:0]    rd_r [256];
  logic          rd_l [256];
  int            rd_n, rd_first, rd_unstable;
  logic [1:0]    wr_resp;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic longint beat_word(input logic [39:0] a, input logic [1:0] b, input int i);
    longint w;
    w = (longint'(a) - longint'(BASE)) / 16;
    return w + ((b == 2'b01) ? i : 0);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [39:0] a, input int len, input logic [1:0] b);
    longint first, last;
    if (b > 2'b01) return 2'b10;
    if (a < BASE) return 2'b11;
    first = beat_word(a, b, 0);
    last  = beat_word(a, b, len);
    if (first >= DEPTH || last >= DEPTH) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [39:0] a, input logic [1:0] b, input int i);
    longint w;
    w = beat_word(a, b, i);
    if (b > 2'b01 || a < BASE || w >= DEPTH) return '0;
    return ref_mem[w];
  endfunction

  function automatic bit rd_checkable(input logic [39:0] a, input logic [1:0] b, input int i);
    longint w;
    w = beat_word(a, b, i);
    if (b > 2'b01 || a < BASE || w >= DEPTH) return 1'b1;
    return ref_known[w];
  endfunction

  function automatic void model_write(input logic [39:0] a, input int len, input logic [1:0] b);
    longint w;
    if (b > 2'b01 || a < BASE) return;
    for (int i = 0; i <= len; i++) begin
      w = beat_word(a, b, i);
      if (w < DEPTH) begin
        for (int k = 0; k < 16; k++)
          if (ws_a[i][k]) ref_mem[w][k*8 +: 8] = wd_a[i][k*8 +: 8];
        ref_known[w] = ref_known[w] || (ws_a[i] == 16'hFFFF);
      end
    end
  endfunction

  task automatic do_write(input logic [39:0] a, input int len, input logic [1:0] b,
                          input int last_beat);
    bit ok;
    awaddr = a; awlen = 8'(len); awburst = b; awsize = 3'd4; awvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = awready; end
    if (!ok) begin checks++; errors++; $display("FAIL aw_timeout awready=0 required=1"); end
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      wdata = wd_a[i]; wstrb = ws_a[i]; wlast = (i == last_beat); wvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = wready; end
      if (!ok) begin checks++; errors++; $display("FAIL w_timeout beat=%0d wready=0 required=1", i); end
      @(posedge clk); #1; wvalid = 1'b0; wlast = 1'b0;
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = bvalid; end
    if (!ok) begin checks++; errors++; $display("FAIL b_timeout bvalid=0 required=1"); end
    wr_resp = bresp;
    @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic do_read(input logic [39:0] a, input int len, input logic [1:0] b,
                         input bit hold, input int stop);
    bit ok, pend;
    int held;
    logic [DW-1:0] s_d;
    logic [1:0] s_r;
    logic s_l;
    araddr = a; arlen = 8'(len); arburst = b; arsize = 3'd4; arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = arready; end
    if (!ok) begin checks++; errors++; $display("FAIL ar_timeout arready=0 required=1"); end
    @(posedge clk); #1; arvalid = 1'b0;
    rd_n = 0; rd_first = -1; rd_unstable = 0; held = 0; pend = 1'b0;
    s_d = '0; s_r = '0; s_l = 1'b0;
    for (int cyc = 0; cyc < 400 && rd_n < stop; cyc++) begin
      @(negedge clk);
      if (rvalid && rd_first < 0) rd_first = cyc;
      if (pend && (rvalid !== 1'b1 || rdata !== s_d || rresp !== s_r || rlast !== s_l))
        rd_unstable++;
      pend = 1'b0;
      if (rvalid && rready) begin
        rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_n++;
      end else if (rvalid) begin
        pend = 1'b1; s_d = rdata; s_r = rresp; s_l = rlast;
      end
      @(posedge clk); #1;
      if (hold) begin
        if (rd_first >= 0 && held < 3) begin rready = 1'b0; held++; end
        else rready = (rd_first >= 0);
      end else begin
        rready = ($urandom_range(0, 3) != 0);
      end
    end
    if (rd_n < stop) begin checks++; errors++; $display("FAIL r_timeout beats=%0d required=%0d", rd_n, stop); end
    rready = 1'b0;
  endtask

  task automatic check_read(input string nm, input logic [39:0] a, input int len,
                            input logic [1:0] b);
    for (int i = 0; i <= len && i < rd_n; i++) begin
      if (rd_checkable(a, b, i)) begin
        checks++;
        if (rd_d[i] !== exp_rd(a, b, i)) begin
          errors++; $display("FAIL %s_rdata beat=%0d got=%h required=%h", nm, i, rd_d[i], exp_rd(a, b, i));
        end
      end
      checks++;
      if (rd_r[i] !== exp_resp(a, len, b)) begin
        errors++; $display("FAIL %s_rresp beat=%0d got=%0d required=%0d", nm, i, rd_r[i], exp_resp(a, len, b));
      end
      checks++;
      if (rd_l[i] !== (i == len)) begin
        errors++; $display("FAIL %s_rlast beat=%0d got=%0b required=%0b", nm, i, rd_l[i], (i == len));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got=%b required=1", awready); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b required=1", arready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b required=0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got=%b required=0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b required=0", rvalid); end
    checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got=%b required=0", rlast); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got=%0d required=0", bresp); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got=%0d required=0", rresp); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'hFFFF; end
      do_write(40'(blk * 256), 15, 2'b01, 15);
      checks++; if (wr_resp !== 2'b00) begin errors++; $display("FAIL fill_bresp blk=%0d got=%0d required=0", blk, wr_resp); end
      model_write(40'(blk * 256), 15, 2'b01);
    end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'hFFFF; end
    do_write(40'h100, 3, 2'b01, 3);
    checks++; if (wr_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%0d required=0", wr_resp); end
    model_write(40'h100, 3, 2'b01);
    do_read(40'h100, 3, 2'b01, 1'b0, 4);
    check_read("incr", 40'h100, 3, 2'b01);
  endtask

  task automatic test_strobe();
    logic [DW-1:0] req;
    req = {{96{1'b1}}, 32'h0};
    wd_a[0] = '1; ws_a[0] = 16'hFFFF;
    do_write(40'h200, 0, 2'b01, 0);
    model_write(40'h200, 0, 2'b01);
    wd_a[0] = '0; ws_a[0] = 16'h000F;
    do_write(40'h200, 0, 2'b01, 0);
    model_write(40'h200, 0, 2'b01);
    do_read(40'h200, 0, 2'b01, 1'b0, 1);
    checks++; if (rd_d[0] !== req) begin errors++; $display("FAIL strobe_rdata got=%h required=%h", rd_d[0], req); end
    check_read("strobe", 40'h200, 0, 2'b01);
  endtask

  task automatic test_latency_hold();
    do_read(40'h300, 2, 2'b01, 1'b1, 3);
    checks++; if (rd_first !== LAT + 1) begin errors++; $display("FAIL latency got=%0d required=%0d", rd_first, LAT + 1); end
    checks++; if (rd_unstable !== 0) begin errors++; $display("FAIL hold_stable changes=%0d required=0", rd_unstable); end
    check_read("lat", 40'h300, 2, 2'b01);
  endtask

  task automatic test_decerr();
    logic [39:0] a;
    a = BASE + 40'(DEPTH * 16 - 16);
    do_read(a, 1, 2'b01, 1'b0, 2);
    checks++; if (rd_r[0] !== 2'b11 || rd_r[1] !== 2'b11) begin
      errors++; $display("FAIL decerr_rresp got=%0d,%0d required=3,3", rd_r[0], rd_r[1]);
    end
    checks++; if (rd_d[1] !== '0) begin errors++; $display("FAIL decerr_rdata1 got=%h required=0", rd_d[1]); end
    check_read("decerr_rd", a, 1, 2'b01);
    for (int i = 0; i < 2; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'hFFFF; end
    do_write(a, 1, 2'b01, 1);
    checks++; if (wr_resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp got=%0d required=3", wr_resp); end
    model_write(a, 1, 2'b01);
    do_read(a, 0, 2'b01, 1'b0, 1);
    check_read("decerr_wr", a, 0, 2'b01);
  endtask

  task automatic test_slverr();
    for (int i = 0; i < 3; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'hFFFF; end
    do_write(40'd40 * 16, 2, 2'b01, 1);
    checks++; if (wr_resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp got=%0d required=2", wr_resp); end
    for (int i = 40; i < 43; i++) ref_known[i] = 1'b0;
    do_read(40'h100, 3, 2'b10, 1'b0, 4);
    check_read("wrap_rd", 40'h100, 3, 2'b10);
    wd_a[0] = rnd128(); ws_a[0] = 16'hFFFF;
    do_write(40'd5 * 16, 0, 2'b10, 0);
    checks++; if (wr_resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got=%0d required=2", wr_resp); end
    do_read(40'd5 * 16, 0, 2'b01, 1'b0, 1);
    check_read("wrap_nowrite", 40'd5 * 16, 0, 2'b01);
    for (int i = 0; i < 4; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'hFFFF; end
    do_write(40'd10 * 16, 3, 2'b00, 3);
    checks++; if (wr_resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got=%0d required=0", wr_resp); end
    model_write(40'd10 * 16, 3, 2'b00);
    do_read(40'd10 * 16, 2, 2'b00, 1'b0, 3);
    check_read("fixed_rd", 40'd10 * 16, 2, 2'b00);
  endtask

  task automatic test_random();
    logic [39:0] a;
    logic [1:0]  b;
    int len;
    for (int it = 0; it < 16; it++) begin
      a = 40'($urandom_range(0, DEPTH + 3)) * 16 + 40'($urandom_range(0, 15));
      b = 2'($urandom_range(0, 1));
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin wd_a[i] = rnd128(); ws_a[i] = 16'($urandom); end
      do_write(a, len, b, len);
      checks++; if (wr_resp !== exp_resp(a, len, b)) begin
        errors++; $display("FAIL rand_bresp it=%0d got=%0d required=%0d", it, wr_resp, exp_resp(a, len, b));
      end
      model_write(a, len, b);
      a = 40'($urandom_range(0, DEPTH + 3)) * 16;
      b = 2'($urandom_range(0, 1));
      len = $urandom_range(0, 7);
      do_read(a, len, b, 1'b0, len + 1);
      check_read("rand", a, len, b);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_read(40'h000, 7, 2'b01, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b required=0", rvalid); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL midrst_arready got=%b required=1", arready); end
    @(posedge clk); #1;
    do_read(40'h000, 3, 2'b01, 1'b0, 4);
    check_read("after_rst", 40'h000, 3, 2'b01);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr_burst();
    test_strobe();
    test_latency_hold();
    test_decerr();
    test_slverr();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
